// File: rtl/hash_arbiter_pkg.sv
// Shared types and constants for the hash arbiter: the 5-tuple, the default
// hash latency and the lookup3 (Bob Jenkins) mix/final helpers.
package hash_arbiter_pkg;

    localparam int unsigned HashLatDefault = 8;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  proto;
    } tuple_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } abc_t;

    // hashword() seed for a 4-word key: 0xdeadbeef + (4 << 2)
    localparam logic [31:0] Lookup3Seed = 32'hdeadbeef + 32'd16;

    function automatic logic [31:0] rot(input logic [31:0] x, input int unsigned k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic abc_t lookup3_mix(input abc_t s);
        abc_t r;
        r = s;
        r.a = r.a - r.c;  r.a = r.a ^ rot(r.c, 4);   r.c = r.c + r.b;
        r.b = r.b - r.a;  r.b = r.b ^ rot(r.a, 6);   r.a = r.a + r.c;
        r.c = r.c - r.b;  r.c = r.c ^ rot(r.b, 8);   r.b = r.b + r.a;
        r.a = r.a - r.c;  r.a = r.a ^ rot(r.c, 16);  r.c = r.c + r.b;
        r.b = r.b - r.a;  r.b = r.b ^ rot(r.a, 19);  r.a = r.a + r.c;
        r.c = r.c - r.b;  r.c = r.c ^ rot(r.b, 4);   r.b = r.b + r.a;
        return r;
    endfunction

    function automatic logic [31:0] lookup3_final(input abc_t s);
        abc_t r;
        r = s;
        r.c = r.c ^ r.b;  r.c = r.c - rot(r.b, 14);
        r.a = r.a ^ r.c;  r.a = r.a - rot(r.c, 11);
        r.b = r.b ^ r.a;  r.b = r.b - rot(r.a, 25);
        r.c = r.c ^ r.b;  r.c = r.c - rot(r.b, 16);
        r.a = r.a ^ r.c;  r.a = r.a - rot(r.c, 4);
        r.b = r.b ^ r.a;  r.b = r.b - rot(r.a, 14);
        r.c = r.c ^ r.b;  r.c = r.c - rot(r.b, 24);
        return r.c;
    endfunction

endpackage

// File: rtl/hash_arbiter_func.sv
// hash_func: lookup3 hashword() over the 4-word tuple key, HASH_LAT cycles deep.
// Datapath registers are intentionally not reset; the caller tracks validity.
module hash_func
    import hash_arbiter_pkg::*;
#(
    parameter int unsigned HASH_LAT = HashLatDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] initval,
    input  tuple_t      tuple_in,
    input  logic        tuple_in_valid,
    output logic [31:0] hashed,
    output logic        hashed_valid
);

    abc_t                         seed;
    abc_t                         mixed;
    abc_t                         abc_q;
    logic [HASH_LAT-2:0][31:0]    hash_q;
    logic [HASH_LAT-1:0]          vld_q;

    always_comb begin
        seed.a  = Lookup3Seed + initval + tuple_in.src_ip;
        seed.b  = Lookup3Seed + initval + tuple_in.dst_ip;
        seed.c  = Lookup3Seed + initval + {tuple_in.src_port, tuple_in.dst_port};
        mixed   = lookup3_mix(seed);
        // Fourth key word goes into the tail, after the single full-block mix
        mixed.a = mixed.a + {24'h0, tuple_in.proto};
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            abc_q     <= mixed;
            vld_q     <= {vld_q[HASH_LAT-2:0], tuple_in_valid};
            hash_q[0] <= lookup3_final(abc_q);
            for (int i = 1; i < HASH_LAT - 1; i++) begin
                hash_q[i] <= hash_q[i-1];
            end
        end
    end

    assign hashed       = hash_q[HASH_LAT-2];
    assign hashed_valid = vld_q[HASH_LAT-1] & ~rst;

endmodule

// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one hash_func pipeline among NUM_REQ requesters,
// with a locally reset valid/id shadow pipeline and output backpressure.
module hash_arbiter
    import hash_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned HASH_LAT = HashLatDefault
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                initval,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  tuple_t [NUM_REQ-1:0]       req_tuple,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [31:0]                out_hash,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    input  logic                       out_ready,
    output logic [3:0]                 inflight
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [IdW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]                grant_idx, cand;
    logic                          any_valid;
    logic                          stall;
    logic                          transfer;
    tuple_t                        grant_tuple;
    logic [HASH_LAT-1:0]           vld_q, vld_d;
    logic [HASH_LAT-1:0][IdW-1:0]  id_q, id_d;
    logic                          unused_hashed_valid;

    assign out_valid = vld_q[HASH_LAT-1];
    assign out_id    = id_q[HASH_LAT-1];
    assign stall     = out_valid & ~out_ready;
    // rst_n gates the strobe so nothing is offered while reset is held
    assign transfer  = any_valid & ~stall & rst_n;

    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                grant_idx = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
        grant_tuple = req_tuple[grant_idx];
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        vld_d    = vld_q;
        id_d     = id_q;
        if (transfer) begin
            rr_ptr_d = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        if (!stall) begin
            vld_d = {vld_q[HASH_LAT-2:0], transfer};
            id_d  = {id_q[HASH_LAT-2:0], grant_idx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            vld_q    <= '0;
            id_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
        end
    end

    always_comb begin
        inflight = 4'($countones(vld_q));
    end

    hash_func #(
        .HASH_LAT(HASH_LAT)
    ) u_hash_func (
        .clk           (clk),
        .rst           (~rst_n),
        .stall         (stall),
        .initval       (initval),
        .tuple_in      (grant_tuple),
        .tuple_in_valid(transfer),
        .hashed        (out_hash),
        .hashed_valid  (unused_hashed_valid)
    );

endmodule

// File: tb/tb_hash_arbiter.sv
// Self-checking bench for hash_arbiter: cycle model + result scoreboard,
// arbitration vector table and hand-written multi-cycle sequences.
module tb_hash_arbiter;
    import hash_arbiter_pkg::*;

    localparam int N = 4;
    localparam int L = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       initval = '0;
    logic [N-1:0]      req_valid = '0;
    tuple_t [N-1:0]    req_tuple = '0;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [31:0]       out_hash;
    logic [1:0]        out_id;
    logic              out_ready = 1'b1;
    logic [3:0]        inflight;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] hash;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] rv;
        logic       ordy;
        logic [3:0] exp_ready;
    } vec_t;
    vec_t vecs[14];

    hash_arbiter #(
        .NUM_REQ (N),
        .HASH_LAT(L)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .initval  (initval),
        .req_valid(req_valid),
        .req_tuple(req_tuple),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_hash (out_hash),
        .out_id   (out_id),
        .out_ready(out_ready),
        .inflight (inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    // Reference lookup3 hashword(k, 4, iv) written out as in the C source
    function automatic logic [31:0] ref_hash(input tuple_t t, input logic [31:0] iv);
        logic [31:0] k[4];
        logic [31:0] a, b, c;
        k[0] = t.src_ip;
        k[1] = t.dst_ip;
        k[2] = {t.src_port, t.dst_port};
        k[3] = {24'h0, t.proto};
        a = 32'hdeadbeef + (32'd4 << 2) + iv;
        b = a;
        c = a;
        a += k[0]; b += k[1]; c += k[2];
        a -= c; a ^= rol(c, 4);  c += b;
        b -= a; b ^= rol(a, 6);  a += c;
        c -= b; c ^= rol(b, 8);  b += a;
        a -= c; a ^= rol(c, 16); c += b;
        b -= a; b ^= rol(a, 19); a += c;
        c -= b; c ^= rol(b, 4);  b += a;
        a += k[3];
        c ^= b; c -= rol(b, 14);
        a ^= c; a -= rol(c, 11);
        b ^= a; b -= rol(a, 25);
        c ^= b; c -= rol(b, 16);
        a ^= c; a -= rol(c, 4);
        b ^= a; b -= rol(a, 14);
        c ^= b; c -= rol(b, 24);
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [N-1:0] rv, input logic ordy);
        tuple_t t;
        @(posedge clk);
        #1;
        req_valid = rv;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            t.src_ip   = $urandom;
            t.dst_ip   = $urandom;
            t.src_port = 16'($urandom);
            t.dst_port = 16'($urandom);
            t.proto    = 8'($urandom);
            req_tuple[i] = t;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Cycle model and scoreboard, evaluated between edges
    initial begin : monitor
        logic [1:0]   m_rr;
        logic [L-1:0] m_vld;
        logic         m_stall, m_any;
        logic [1:0]   m_win;
        logic [N-1:0] m_ready;
        int           idx;
        m_rr  = '0;
        m_vld = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_rr  = '0;
                m_vld = '0;
                sb.delete();
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_req_ready", 64'(req_ready), 64'd0);
                check("rst_inflight", 64'(inflight), 64'd0);
            end else begin
                m_stall = m_vld[L-1] && !out_ready;
                m_any   = 1'b0;
                m_win   = '0;
                for (int k = 0; k < N; k++) begin
                    idx = (int'(m_rr) + k) % N;
                    if (!m_any && req_valid[idx]) begin
                        m_any = 1'b1;
                        m_win = 2'(idx);
                    end
                end
                m_ready = (m_any && !m_stall) ? (N'(1) << m_win) : '0;
                check("mon_req_ready", 64'(req_ready), 64'(m_ready));
                check("mon_out_valid", 64'(out_valid), 64'(m_vld[L-1]));
                check("mon_inflight", 64'(inflight), 64'($countones(m_vld)));
                if (m_vld[L-1]) begin
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 64'd0, 64'd1);
                    end else begin
                        check("sb_out_id", 64'(out_id), 64'(sb[0].id));
                        check("sb_out_hash", 64'(out_hash), 64'(sb[0].hash));
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                if (!m_stall) begin
                    m_vld = {m_vld[L-2:0], m_any};
                    if (m_any) begin
                        sb.push_back('{id: m_win, hash: ref_hash(req_tuple[m_win], initval)});
                        m_rr = (m_win == 2'(N - 1)) ? 2'd0 : m_win + 2'd1;
                    end
                end
            end
        end
    end

    initial begin : main
        logic [31:0] exp_hash;

        vecs[0]  = '{4'b0000, 1'b1, 4'b0000};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0100};
        vecs[2]  = '{4'b1010, 1'b1, 4'b1000};  // rr=3, wraps to 0
        vecs[3]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[5]  = '{4'b1001, 1'b1, 4'b1000};
        vecs[6]  = '{4'b0110, 1'b1, 4'b0010};
        vecs[7]  = '{4'b0011, 1'b1, 4'b0001};
        vecs[8]  = '{4'b0011, 1'b1, 4'b0010};
        vecs[9]  = '{4'b0100, 1'b1, 4'b0100};
        vecs[10] = '{4'b0010, 1'b1, 4'b0010};  // rr=3, skip to req 1
        vecs[11] = '{4'b0100, 1'b1, 4'b0100};
        vecs[12] = '{4'b1000, 1'b1, 4'b1000};
        vecs[13] = '{4'b0001, 1'b1, 4'b0001};

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_inflight", 64'(inflight), 64'd0);
        rst_n = 1'b1;

        // Arbitration table
        initval = 32'h1234_5678;
        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].rv, vecs[i].ordy);
            check($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
        end
        repeat (12) step('0, 1'b1);
        check("table_drained", 64'(inflight), 64'd0);

        // Single request latency
        initval = 32'h0;
        do_reset();
        step(4'b0100, 1'b1);
        check("a_ready", 64'(req_ready), 64'b0100);
        exp_hash = ref_hash(req_tuple[2], 32'h0);
        for (int k = 1; k <= 9; k++) begin
            step('0, 1'b1);
            check($sformatf("a_out_valid_%0d", k), 64'(out_valid), 64'(k == 8));
            check($sformatf("a_inflight_%0d", k), 64'(inflight), (k <= 8) ? 64'd1 : 64'd0);
            if (k == 8) begin
                check("a_out_id", 64'(out_id), 64'd2);
                check("a_out_hash", 64'(out_hash), 64'(exp_hash));
            end
        end

        // Continuous round robin at full throughput
        initval = 32'hcafe_f00d;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(4'b1111, 1'b1);
            check($sformatf("b_grant_%0d", c), 64'(req_ready), 64'(1 << (c % 4)));
            if (c >= 8) begin
                check($sformatf("b_out_valid_%0d", c), 64'(out_valid), 64'd1);
                check($sformatf("b_out_id_%0d", c), 64'(out_id), 64'((c - 8) % 4));
            end
        end

        // Backpressure on a full pipeline
        for (int s = 0; s < 5; s++) begin
            step(4'b1111, 1'b0);
            check($sformatf("c_ready_%0d", s), 64'(req_ready), 64'd0);
            check($sformatf("c_inflight_%0d", s), 64'(inflight), 64'd8);
            check($sformatf("c_out_valid_%0d", s), 64'(out_valid), 64'd1);
            check($sformatf("c_out_id_%0d", s), 64'(out_id), 64'd0);
        end
        for (int j = 0; j < 12; j++) begin
            step(4'b1111, 1'b1);
            check($sformatf("c_rel_grant_%0d", j), 64'(req_ready), 64'(1 << (j % 4)));
            check($sformatf("c_rel_out_id_%0d", j), 64'(out_id), 64'(j % 4));
        end
        repeat (10) step('0, 1'b1);
        check("c_drained_inflight", 64'(inflight), 64'd0);
        check("c_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with six tuples in flight
        do_reset();
        repeat (6) step(4'b1111, 1'b1);
        step('0, 1'b1);
        check("d_inflight6", 64'(inflight), 64'd6);
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        check("d_rst_out_valid", 64'(out_valid), 64'd0);
        check("d_rst_inflight", 64'(inflight), 64'd0);
        check("d_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step('0, 1'b1);
            check($sformatf("d_no_out_%0d", k), 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_arbiter.md
HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter HASH_LAT, default 8, hash_func accept-to-result latency in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port initval  input  32  hash seed, passed unchanged to hash_func.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester tuple valid.
REQ-007 SHALL have port req_tuple  input  NUM_REQ x tuple_t  per-requester 5-tuple.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept strobe, one-hot or zero.
REQ-009 SHALL have port out_valid  output  1  hash result valid.
REQ-010 SHALL have port out_hash  output  32  hash result.
REQ-011 SHALL have port out_id  output  $clog2(NUM_REQ)  index of the requester that issued the tuple.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have port inflight  output  4  number of valid entries in the pipeline (0..HASH_LAT).

Function
REQ-014 SHALL share one hash_func pipeline among NUM_REQ requesters, accepting at most one tuple per cycle.
REQ-015 SHALL grant by round-robin: search starts at rr_ptr, and the first i (mod NUM_REQ) with req_valid[i]=1 wins.
REQ-016 SHALL drive req_ready[i]=1 combinationally iff i is the winner and stall=0; a transfer occurs when req_valid[i] & req_ready[i].
REQ-017 SHALL load rr_ptr with (winner+1) mod NUM_REQ on every transfer, and hold rr_ptr otherwise; wrap from NUM_REQ-1 to 0.
REQ-018 SHALL compute stall = out_valid & ~out_ready, drive it to hash_func.stall, and freeze all of its own pipeline state while stall=1.
REQ-019 SHALL keep its own HASH_LAT-deep valid/id shift register in step with hash_func, and SHALL NOT use hash_func.hashed_valid, because hash_func's registers are not reset.
REQ-020 SHALL present a tuple transferred at edge t as out_valid=1 after exactly HASH_LAT unstalled edges, with out_hash = hash_func.hashed and out_id = the granted index.
REQ-021 SHALL hold out_valid, out_hash and out_id stable while stall=1.
REQ-022 SHALL accept a new tuple in the same cycle that the output is consumed (out_valid & out_ready), giving full throughput of 1 result per cycle.
REQ-023 SHALL keep inflight equal to the popcount of the valid shift register; simultaneous entry and exit leave it unchanged.
REQ-024 SHALL ignore req_tuple of non-granted requesters, and SHALL mux the granted tuple to hash_func.tuple_in.
REQ-025 SHALL feed hash_func.tuple_in_valid = transfer, and tuple_in_valid SHALL be 0 when no requester is valid.

Reset
REQ-026 SHALL, while rst_n=0, immediately force out_valid=0, req_ready=0, inflight=0, rr_ptr=0, and all valid and id stages to 0.
REQ-027 SHALL discard all in-flight tuples on reset mid-operation; no result issued before reset SHALL emerge after rst_n rises.
REQ-028 SHALL tie hash_func.rst to ~rst_n; hash_func datapath contents after reset are don't-care, masked by REQ-019.

Structure
REQ-029 SHALL take tuple_t from the shared struct package; HASH_LAT's default of 8 SHALL live there as a shared constant beside tuple_t.
REQ-030 SHALL instantiate exactly one sub-module, hash_func; the arbiter, mux and tag/valid pipeline are local logic.

Verification
REQ-031 Single request: req_valid=4'b0100 for one transfer, initval=0 -> after 8 edges out_valid=1, out_id=2, out_hash = C-model lookup3 result; inflight steps 1 to 0.
REQ-032 Round-robin with all requesters valid continuously and out_ready=1 -> grants are 0,1,2,3,0,1...; out_id follows the same sequence 8 cycles later, one result per cycle.
REQ-033 Backpressure: full pipeline, then out_ready=0 for 5 cycles -> req_ready=0, out_* held, inflight=8; on release results resume in order, with none lost or duplicated.
REQ-034 Reset mid-flight: rst_n low for 1 cycle with inflight=6 -> out_valid=0 at once; no out_valid for 8 cycles after release unless new tuples are accepted.
REQ-035 Pointer wrap and skip: rr_ptr=3 with only req 1 valid -> req 1 granted and rr_ptr becomes 2; rr_ptr=3 with req 3 valid -> rr_ptr wraps to 0.
